// File: rtl/fpu.sv
// fpu: sequential floating-point adder, 1/6/25 format (sign, exponent bias 31, mantissa).
// Free-running LOAD->ALIGN->ADD->NORM->ROUND->WRITE loop; results and status held between WRITEs.
// Build option: define FPU_ROUND_NEAREST_EN for round-to-nearest-even, otherwise truncation.
module fpu (
    input  logic        clock100KHz,
    input  logic        reset,
    input  logic [31:0] op_A_in,
    input  logic [31:0] op_B_in,
    output logic [31:0] data_out,
    output logic [3:0]  status_out
);
    localparam int unsigned EXP_W     = 6;
    localparam int unsigned MAN_W     = 25;
    localparam int unsigned SIG_W     = MAN_W + 1;      // hidden bit + mantissa
    localparam int unsigned WRK_W     = SIG_W + 4;      // carry + significand + G/R/S
    localparam int unsigned SHF_W     = SIG_W + 28;     // significand + 28 shifted-out bits
    localparam int unsigned MAX_SHIFT = 28;

    typedef enum logic [2:0] {LOAD, ALIGN, ADD, NORM, ROUND, WRITE} state_t;
    state_t state, state_next;

    logic                    sign_a, sign_b, sign_big, sign_small;
    logic [EXP_W-1:0]        exp_a, exp_b;
    logic [SIG_W-1:0]        sig_a, sig_b, sig_big, sig_small;
    logic [2:0]              grs_small;
    logic signed [7:0]       exp_res;
    logic [WRK_W-1:0]        work;
    logic                    zero_res;
    logic                    inexact;

    logic                    a_is_big_c;
    logic [EXP_W-1:0]        exp_diff_c;
    logic [SIG_W-1:0]        sig_small_pre_c;
    logic [SHF_W-1:0]        shifted_c;
    logic [WRK_W-1:0]        big_ext_c, small_ext_c, sum_c;
    logic                    round_up_c;
    logic [SIG_W:0]          rounded_c;
    logic [31:0]             result_c;
    logic [3:0]              status_c;

    // Magnitude compare and alignment shift of the smaller operand
    always_comb begin
        a_is_big_c      = ({exp_a, sig_a} >= {exp_b, sig_b});
        exp_diff_c      = a_is_big_c ? (exp_a - exp_b) : (exp_b - exp_a);
        sig_small_pre_c = a_is_big_c ? sig_b : sig_a;
        shifted_c       = {sig_small_pre_c, 28'd0} >> exp_diff_c;
    end

    // Significand add/subtract including the guard/round/sticky bits
    always_comb begin
        big_ext_c   = {1'b0, sig_big, 3'b000};
        small_ext_c = {1'b0, sig_small, grs_small};
        sum_c       = (sign_big == sign_small) ? (big_ext_c + small_ext_c)
                                               : (big_ext_c - small_ext_c);
    end

    // Rounding increment from G/R/S and the significand LSB
    always_comb begin
`ifdef FPU_ROUND_NEAREST_EN
        round_up_c = work[2] & (work[1] | work[0] | work[3]);
`else
        round_up_c = 1'b0;
`endif
        rounded_c = {1'b0, work[WRK_W-2:3]} + (SIG_W+1)'(round_up_c);
    end

    // Result packing and one-hot status classification
    always_comb begin
        result_c = '0;
        status_c = 4'b0001;
        if (zero_res) begin
            result_c = '0;
            status_c = 4'b0001;
        end else if (exp_res > 8'sd62) begin
            result_c = {sign_big, 6'd63, 25'd0};
            status_c = 4'b0010;
        end else if (exp_res < 8'sd1) begin
            result_c = '0;
            status_c = 4'b0100;
        end else begin
            result_c = {sign_big, exp_res[EXP_W-1:0], work[WRK_W-3:3]};
            status_c = inexact ? 4'b1000 : 4'b0001;
        end
    end

    // State register
    always_ff @(posedge clock100KHz) begin
        if (reset) state <= LOAD;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            LOAD:    state_next = ALIGN;
            ALIGN:   state_next = ADD;
            ADD:     state_next = (sum_c == '0) ? ROUND : NORM;
            NORM:    if (work[WRK_W-1] || work[WRK_W-2]) state_next = ROUND;
            ROUND:   state_next = WRITE;
            WRITE:   state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    // Datapath registers and output registers, advanced per state
    always_ff @(posedge clock100KHz) begin
        if (reset) begin
            data_out   <= '0;
            status_out <= '0;
        end else begin
            case (state)
                LOAD: begin
                    sign_a <= op_A_in[31];
                    exp_a  <= op_A_in[30:25];
                    sig_a  <= (op_A_in[30:25] == '0) ? '0 : {1'b1, op_A_in[24:0]};
                    sign_b <= op_B_in[31];
                    exp_b  <= op_B_in[30:25];
                    sig_b  <= (op_B_in[30:25] == '0) ? '0 : {1'b1, op_B_in[24:0]};
                end
                ALIGN: begin
                    sign_big   <= a_is_big_c ? sign_a : sign_b;
                    sign_small <= a_is_big_c ? sign_b : sign_a;
                    sig_big    <= a_is_big_c ? sig_a : sig_b;
                    exp_res    <= 8'(a_is_big_c ? exp_a : exp_b);
                    if (exp_diff_c > EXP_W'(MAX_SHIFT)) begin
                        sig_small <= '0;
                        grs_small <= {2'b00, |sig_small_pre_c};
                    end else begin
                        sig_small <= shifted_c[SHF_W-1:28];
                        grs_small <= {shifted_c[27], shifted_c[26], |shifted_c[25:0]};
                    end
                end
                ADD: begin
                    work     <= sum_c;
                    zero_res <= (sum_c == '0);
                end
                NORM: begin
                    if (work[WRK_W-1]) begin
                        work    <= {1'b0, work[WRK_W-1:2], work[1] | work[0]};
                        exp_res <= exp_res + 8'sd1;
                    end else if (!work[WRK_W-2]) begin
                        work    <= {work[WRK_W-2:0], 1'b0};
                        exp_res <= exp_res - 8'sd1;
                    end
                end
                ROUND: begin
                    inexact <= |work[2:0];
                    if (rounded_c[SIG_W]) begin
                        work[WRK_W-2:3] <= rounded_c[SIG_W:1];
                        exp_res         <= exp_res + 8'sd1;
                    end else begin
                        work[WRK_W-2:3] <= rounded_c[SIG_W-1:0];
                    end
                end
                WRITE: begin
                    data_out   <= result_c;
                    status_out <= status_c;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu.sv
// tb_fpu: table-driven scoreboard bench for the sequential fpu adder.
module tb_fpu;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] op_a, op_b;
    logic [31:0] data_out;
    logic [3:0]  status_out;

    always #5 clk = ~clk;

    fpu dut (
        .clock100KHz(clk),
        .reset      (reset),
        .op_A_in    (op_a),
        .op_B_in    (op_b),
        .data_out   (data_out),
        .status_out (status_out)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  st;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  st;
        int          id;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] fp(input logic s, input logic [5:0] e, input logic [24:0] m);
        return {s, e, m};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s[%0d]: got %h, required %h", name, id, act, req);
        end
    endtask

    task automatic add_vec(input logic [31:0] a, input logic [31:0] b, input logic [31:0] res, input logic [3:0] st);
        vec_t v;
        v.a = a; v.b = b; v.res = res; v.st = st;
        vecs.push_back(v);
    endtask

    // Hold reset with new operands, check the reset state, push the expectation, release
    task automatic start_op(input vec_t v, input int id);
        exp_t e;
        reset = 1'b1;
        op_a  = v.a;
        op_b  = v.b;
        tick();
        tick();
        check("reset_data", id, data_out, 32'd0);
        check("reset_status", id, 32'(status_out), 32'd0);
        e.res = v.res; e.st = v.st; e.id = id;
        sb.push_back(e);
        reset = 1'b0;
    endtask

    // Wait (bounded) for the outputs to leave their old value, then pop and compare
    task automatic wait_write(input logic [31:0] old_d, input logic [3:0] old_s);
        int   n = 0;
        exp_t e;
        while ({data_out, status_out} == {old_d, old_s} && n < 40) begin
            tick();
            n++;
        end
        e = sb.pop_front();
        checks++;
        if ({data_out, status_out} == {old_d, old_s}) begin
            errors++;
            $display("FAIL write_timeout[%0d]: no WRITE after %0d clocks, required within 40", e.id, n);
        end else begin
            check("data", e.id, data_out, e.res);
            check("status", e.id, 32'(status_out), 32'(e.st));
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        start_op(v, id);
        wait_write(32'd0, 4'd0);
    endtask

    initial begin
        vec_t        v;
        exp_t        e;
        logic [31:0] old_d;
        logic [3:0]  old_s;

        reset = 1'b1;
        op_a  = '0;
        op_b  = '0;

        add_vec(fp(0,31,0), fp(0,31,0), fp(0,32,0), 4'b0001);               // 1 + 1
        add_vec(fp(0,31,0), fp(1,31,0), 32'd0, 4'b0001);                    // 1 - 1
        add_vec(fp(0,50,100), fp(0,10,100), fp(0,50,100), 4'b1000);         // sticky-only operand
        add_vec(fp(0,31,25'h0FFFFFF), fp(0,31,1), fp(0,32,25'h0800000), 4'b0001);
        add_vec(fp(0,63,25'h1FFFFFF), fp(0,63,25'h1FFFFFF), fp(0,63,0), 4'b0010);
        add_vec(fp(0,1,1), fp(1,1,0), 32'd0, 4'b0100);                      // underflow
        add_vec(fp(1,32,0), fp(1,32,0), fp(1,33,0), 4'b0001);               // -2 + -2
        add_vec(fp(0,33,0), fp(1,32,0), fp(0,32,0), 4'b0001);               // 4 - 2
        add_vec(fp(0,0,0), fp(0,0,0), 32'd0, 4'b0001);                      // 0 + 0
        add_vec(fp(0,0,123), fp(1,40,25'h155), fp(1,40,25'h155), 4'b0001);  // zero ignores mantissa
        add_vec(fp(0,31,0), fp(0,5,0), fp(0,31,0), 4'b1000);                // tie, even LSB
        add_vec(fp(0,31,0), fp(0,6,0), fp(0,31,1), 4'b0001);                // exact 25-bit shift
        add_vec(fp(0,31,0), fp(0,4,25'h1000000), fp(0,31,0), 4'b1000);      // R and S only
        add_vec(fp(0,31,0), fp(1,5,0), fp(0,30,25'h1FFFFFF), 4'b0001);      // borrow through GRS
        add_vec(fp(0,61,0), fp(0,61,0), fp(0,62,0), 4'b0001);               // largest normal exponent
        add_vec(fp(0,62,0), fp(0,62,0), fp(0,63,0), 4'b0010);               // exponent 63 overflows
        add_vec(fp(1,62,0), fp(1,62,0), fp(1,63,0), 4'b0010);               // negative overflow
        add_vec(fp(0,63,0), fp(0,0,0), fp(0,63,0), 4'b0010);                // exponent 63 operand
        add_vec(fp(0,2,0), fp(1,1,0), fp(0,1,0), 4'b0001);                  // smallest normal result
        add_vec(fp(0,40,5), fp(1,40,7), fp(1,16,0), 4'b0001);               // long normalization
`ifdef FPU_ROUND_NEAREST_EN
        add_vec(fp(0,31,1), fp(0,5,0), fp(0,31,2), 4'b1000);                // tie, odd LSB rounds up
        add_vec(fp(0,31,25'h1FFFFFF), fp(0,5,0), fp(0,32,0), 4'b1000);      // rounding carry
`else
        add_vec(fp(0,31,1), fp(0,5,0), fp(0,31,1), 4'b1000);
        add_vec(fp(0,31,25'h1FFFFFF), fp(0,5,0), fp(0,31,25'h1FFFFFF), 4'b1000);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], i);
        end

        // Reset mid-operation abandons the pending overflow result
        reset = 1'b1;
        op_a  = fp(0,63,25'h1FFFFFF);
        op_b  = fp(0,63,25'h1FFFFFF);
        tick();
        reset = 1'b0;
        tick();
        tick();
        tick();
        v.a = fp(0,31,0); v.b = fp(0,31,0); v.res = fp(0,32,0); v.st = 4'b0001;
        run_vec(v, 100);

        // Outputs hold until the next WRITE, then follow new operands without reset
        v.a = fp(1,32,0); v.b = fp(1,32,0); v.res = fp(1,33,0); v.st = 4'b0001;
        run_vec(v, 101);
        old_d = data_out;
        old_s = status_out;
        op_a  = fp(0,33,0);
        op_b  = fp(1,32,0);
        e.res = fp(0,32,0); e.st = 4'b0001; e.id = 102;
        sb.push_back(e);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("hold_data", 102, data_out, fp(1,33,0));
            check("hold_status", 102, 32'(status_out), 32'd1);
        end
        wait_write(old_d, old_s);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
